// File: rtl/reg_fifo.sv
// ============================================================================
// Module      : reg_fifo
// Description : Register-based first-word-fall-through FIFO with a global
//               enable. Optional macro REG_FIFO_ERR_EN adds sticky
//               overflow/underflow flags and their synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
`ifdef REG_FIFO_ERR_EN
  input  logic                       err_clr,
  output logic                       err_ovf,
  output logic                       err_udf,
`endif
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;
  localparam logic [C_CW-1:0] C_CNT_FULL = C_CW'(DEPTH);
  localparam logic [C_CW-1:0] C_CNT_ONE  = C_CW'(1);
  localparam logic [C_AW-1:0] C_PTR_ONE  = C_AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wptr;
  logic [C_AW-1:0]  r_rptr;
  logic [C_CW-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_push_acc;
  logic w_pop_acc;

  // Flags are decoded from the count register only, so reset clears them
  // asynchronously along with the count.
  assign w_full  = (r_count == C_CNT_FULL);
  assign w_empty = (r_count == '0);

  // A push into a full FIFO is still taken when a pop frees the head slot.
  assign w_push_acc = en & push & (~w_full | pop);
  assign w_pop_acc  = en & pop & ~w_empty;

  // Storage is deliberately not reset; the empty mask hides stale words.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_acc) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_pop_acc) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = w_empty ? '0 : r_mem[r_rptr];
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

`ifdef REG_FIFO_ERR_EN
  logic r_err_ovf;
  logic r_err_udf;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_ovf_set = en & push & w_full & ~pop;
  assign w_udf_set = en & pop & w_empty;

  // Clear wins over a set in the same cycle; like all state it obeys en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else if (en) begin
      if (err_clr) begin
        r_err_ovf <= 1'b0;
        r_err_udf <= 1'b0;
      end else begin
        r_err_ovf <= r_err_ovf | w_ovf_set;
        r_err_udf <= r_err_udf | w_udf_set;
      end
    end
  end

  assign err_ovf = r_err_ovf;
  assign err_udf = r_err_udf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_fifo.sv
// Testbench for reg_fifo (WIDTH=5, DEPTH=4) against a queue-based model.
`default_nettype none

module tb_reg_fifo;
  localparam int WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OW    = WIDTH + CW + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
`ifdef REG_FIFO_ERR_EN
  logic             err_clr;
  logic             err_ovf;
  logic             err_udf;
  logic             m_ovf;
  logic             m_udf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] q[$];

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .push  (push),
    .din   (din),
    .pop   (pop),
`ifdef REG_FIFO_ERR_EN
    .err_clr (err_clr),
    .err_ovf (err_ovf),
    .err_udf (err_udf),
`endif
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always #5 clk = ~clk;

  // Expected {dout, count, full, empty} from the queue contents.
  function automatic logic [OW-1:0] exp_outs();
    logic [WIDTH-1:0] d;
    d = (q.size() > 0) ? q[0] : '0;
    return {d, CW'(q.size()), q.size() == DEPTH, q.size() == 0};
  endfunction

  // Applies one clock edge of FIFO rules to the queue.
  task automatic model_step();
    logic was_full, was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (en) begin
`ifdef REG_FIFO_ERR_EN
      if (err_clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else begin
        if (push && was_full && !pop) m_ovf = 1'b1;
        if (pop && was_empty) m_udf = 1'b1;
      end
`endif
      if (pop && !was_empty) void'(q.pop_front());
      if (push && (!was_full || pop)) q.push_back(din);
    end
  endtask

  task automatic cycle(input logic e, input logic p, input logic [WIDTH-1:0] d, input logic o);
    en = e; push = p; din = d; pop = o;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; push = 1'b1; pop = 1'b0; din = 5'h15;
`ifdef REG_FIFO_ERR_EN
    err_clr = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
`endif
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({dout, count, full, empty} !== {5'h00, 3'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outs: got %h expected %h", {dout, count, full, empty}, {5'h00, 3'd0, 1'b0, 1'b1});
    end
    rst = 1'b0; push = 1'b0; en = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b1, WIDTH'(i), 1'b0);
      n_checks++;
      if ({dout, count, full, empty} !== exp_outs()) begin
        n_fail++;
        $display("FAIL fill_step%0d: got %h expected %h", i, {dout, count, full, empty}, exp_outs());
      end
    end
    n_checks++;
    if ({count, full, dout} !== {3'd4, 1'b1, 5'h01}) begin
      n_fail++;
      $display("FAIL fill_final: got %h expected %h", {count, full, dout}, {3'd4, 1'b1, 5'h01});
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dout !== exp_outs()[OW-1 -: WIDTH]) begin
        n_fail++;
        $display("FAIL drain_head%0d: got %h expected %h", i, dout, exp_outs()[OW-1 -: WIDTH]);
      end
      cycle(1'b1, 1'b0, 5'h00, 1'b1);
    end
    n_checks++;
    if ({empty, dout, count} !== {1'b1, 5'h00, 3'd0}) begin
      n_fail++;
      $display("FAIL drain_final: got %h expected %h", {empty, dout, count}, {1'b1, 5'h00, 3'd0});
    end
  endtask

  task automatic test_full_push();
    cycle(1'b1, 1'b1, 5'h1F, 1'b0);
    n_checks++;
    if ({dout, count, full} !== {5'h01, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL full_push_ignored: got %h expected %h", {dout, count, full}, {5'h01, 3'd4, 1'b1});
    end
`ifdef REG_FIFO_ERR_EN
    n_checks++;
    if (err_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL err_ovf_set: got %b expected 1", err_ovf);
    end
`endif
    cycle(1'b1, 1'b1, 5'h1F, 1'b1);
    n_checks++;
    if ({dout, count, full} !== {5'h02, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL full_push_pop: got %h expected %h", {dout, count, full}, {5'h02, 3'd4, 1'b1});
    end
  endtask

  task automatic test_empty_push_pop();
    cycle(1'b1, 1'b1, 5'h0A, 1'b1);
    n_checks++;
    if ({dout, count, empty} !== {5'h0A, 3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL empty_push_pop: got %h expected %h", {dout, count, empty}, {5'h0A, 3'd1, 1'b0});
    end
    cycle(1'b1, 1'b0, 5'h00, 1'b1);
    cycle(1'b1, 1'b0, 5'h00, 1'b1);
    n_checks++;
    if ({dout, count, full, empty} !== exp_outs()) begin
      n_fail++;
      $display("FAIL pop_on_empty: got %h expected %h", {dout, count, full, empty}, exp_outs());
    end
`ifdef REG_FIFO_ERR_EN
    n_checks++;
    if (err_udf !== 1'b1) begin
      n_fail++;
      $display("FAIL err_udf_set: got %b expected 1", err_udf);
    end
    err_clr = 1'b1;
    cycle(1'b1, 1'b0, 5'h00, 1'b0);
    err_clr = 1'b0;
    n_checks++;
    if ({err_ovf, err_udf} !== 2'b00) begin
      n_fail++;
      $display("FAIL err_clr: got %b expected 00", {err_ovf, err_udf});
    end
`endif
  endtask

  task automatic test_enable_wrap();
    cycle(1'b1, 1'b1, 5'h11, 1'b0);
    cycle(1'b1, 1'b1, 5'h12, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(i != 5, 1'b1, WIDTH'(5'h13 + i), 1'b1);
      n_checks++;
      if ({dout, count, full, empty} !== exp_outs()) begin
        n_fail++;
        $display("FAIL en_wrap%0d: got %h expected %h", i, {dout, count, full, empty}, exp_outs());
      end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() < 3) cycle(1'b1, 1'b1, 5'h19, 1'b0);
    while (q.size() > 3) cycle(1'b1, 1'b0, 5'h00, 1'b1);
    en = 1'b0;
    #2 rst = 1'b1;
    q.delete();
`ifdef REG_FIFO_ERR_EN
    m_ovf = 1'b0; m_udf = 1'b0;
`endif
    #1;
    n_checks++;
    if ({dout, count, full, empty} !== {5'h00, 3'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", {dout, count, full, empty}, {5'h00, 3'd0, 1'b0, 1'b1});
    end
    #1 rst = 1'b0;
    cycle(1'b1, 1'b1, 5'h07, 1'b0);
    n_checks++;
    if ({dout, count} !== {5'h07, 3'd1}) begin
      n_fail++;
      $display("FAIL after_reset_push: got %h expected %h", {dout, count}, {5'h07, 3'd1});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
`ifdef REG_FIFO_ERR_EN
      err_clr = ($urandom_range(0, 15) == 0);
`endif
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
            WIDTH'($urandom), $urandom_range(0, 1) == 1);
      n_checks++;
      if ({dout, count, full, empty} !== exp_outs()) begin
        n_fail++;
        $display("FAIL random%0d: got %h expected %h", i, {dout, count, full, empty}, exp_outs());
      end
`ifdef REG_FIFO_ERR_EN
      n_checks++;
      if ({err_ovf, err_udf} !== {m_ovf, m_udf}) begin
        n_fail++;
        $display("FAIL random_err%0d: got %b expected %b", i, {err_ovf, err_udf}, {m_ovf, m_udf});
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_fill();
    test_full_push();
    test_drain();
    test_empty_push_pop();
    test_enable_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
